// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the split-cache physical-memory arbiter.
// Holds the line/word types, the arbiter FSM and selector enums, and the
// latched pmem request payload.
package pmem_arbiter_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LINE_W = 128;

  typedef logic [WORD_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] mem_bus;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t;
  typedef enum logic {SEL_I, SEL_D} arb_sel_t;

  // Request presented on the pmem port for the duration of a grant
  typedef struct packed {
    logic     read;
    logic     write;
    lc3b_word address;
    mem_bus   wdata;
  } pmem_req_t;

endpackage

// File: rtl/arb_priority_select.sv
// Combinational tie-break between the I-cache and D-cache requesters.
// Config macro: ARB_RR_EN (defined = round-robin on ptr, undefined = D wins ties).
// Ports:
//   i_pend, d_pend : requester pending bits
//   ptr            : preferred requester on a tie (round-robin only)
//   sel            : winning requester (don't-care when neither is pending)
module arb_priority_select
  import pmem_arbiter_pkg::*;
(
  input  logic     i_pend,
  input  logic     d_pend,
  input  arb_sel_t ptr,
  output arb_sel_t sel
);

`ifdef ARB_RR_EN
  always_comb begin
    sel = SEL_D;
    if (i_pend && d_pend) sel = ptr;
    else if (i_pend)      sel = SEL_I;
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr;

  always_comb begin
    sel = SEL_D;
    if (i_pend && !d_pend) sel = SEL_I;
  end
`endif

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the single physical-memory port between the I-cache and D-cache.
// One line transaction at a time; the winner's request is latched on grant
// and pmem_resp is routed back to the winner only.
// Config macro: ARB_RR_EN (defined = round-robin ties, undefined = D wins ties).
// Ports:
//   clk, rst_n                              : clock, async active-low reset
//   i_read/i_write/i_address/i_wdata        : I-cache request
//   i_resp, i_rdata                         : I-cache completion and read line
//   d_read/d_write/d_address/d_wdata        : D-cache request
//   d_resp, d_rdata                         : D-cache completion and read line
//   pmem_read/pmem_write/pmem_address/pmem_wdata : registered physical request
//   pmem_resp, pmem_rdata                   : physical completion and read line
module pmem_arbiter
  import pmem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_read,
  input  logic     i_write,
  input  lc3b_word i_address,
  input  mem_bus   i_wdata,
  output logic     i_resp,
  output mem_bus   i_rdata,
  input  logic     d_read,
  input  logic     d_write,
  input  lc3b_word d_address,
  input  mem_bus   d_wdata,
  output logic     d_resp,
  output mem_bus   d_rdata,
  output logic     pmem_read,
  output logic     pmem_write,
  output lc3b_word pmem_address,
  output mem_bus   pmem_wdata,
  input  logic     pmem_resp,
  input  mem_bus   pmem_rdata
);

  arb_state_t state_q, state_d;
  pmem_req_t  req_q, req_d;
  arb_sel_t   sel, ptr;
  logic       i_pend, d_pend;

  assign i_pend = i_read | i_write;
  assign d_pend = d_read | d_write;

  arb_priority_select u_sel (
    .i_pend (i_pend),
    .d_pend (d_pend),
    .ptr    (ptr),
    .sel    (sel)
  );

  // Next-state and request latch; write wins when a cache sets both strobes
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    case (state_q)
      IDLE: begin
        if (i_pend || d_pend) begin
          if (sel == SEL_I) begin
            state_d = GRANT_I;
            req_d   = '{read: i_read & ~i_write, write: i_write,
                        address: i_address, wdata: i_wdata};
          end else begin
            state_d = GRANT_D;
            req_d   = '{read: d_read & ~d_write, write: d_write,
                        address: d_address, wdata: d_wdata};
          end
        end
      end
      GRANT_I, GRANT_D: begin
        if (pmem_resp) begin
          state_d     = IDLE;
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

`ifdef ARB_RR_EN
  // Preferred requester moves to the other side after each completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= SEL_I;
    else if (i_resp) ptr <= SEL_D;
    else if (d_resp) ptr <= SEL_I;
  end
`else
  assign ptr = SEL_I;
`endif

  // Completion is routed combinationally to the granted side only
  assign i_resp = (state_q == GRANT_I) && pmem_resp;
  assign d_resp = (state_q == GRANT_D) && pmem_resp;

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  assign pmem_read    = req_q.read;
  assign pmem_write   = req_q.write;
  assign pmem_address = req_q.address;
  assign pmem_wdata   = req_q.wdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Self-checking bench for pmem_arbiter: per-cycle vector table for the
// single-requester flows, plus sequences for ties, starvation/alternation,
// mid-grant reset and stray pmem_resp.
module tb_pmem_arbiter;
  import pmem_arbiter_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     i_read, i_write, d_read, d_write, pmem_resp;
  lc3b_word i_address, d_address;
  mem_bus   i_wdata, d_wdata, pmem_rdata;
  logic     i_resp, d_resp, pmem_read, pmem_write;
  mem_bus   i_rdata, d_rdata, pmem_wdata;
  lc3b_word pmem_address;

  int checks = 0;
  int errors = 0;

  localparam mem_bus LINE_A5 = {16{8'hA5}};
  localparam mem_bus LINE_12 = {8{16'h1234}};
  localparam mem_bus LINE_I  = {16{8'h5A}};

  always #5 clk = ~clk;

  pmem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_write      (i_write),
    .i_address    (i_address),
    .i_wdata      (i_wdata),
    .i_resp       (i_resp),
    .i_rdata      (i_rdata),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_resp       (d_resp),
    .d_rdata      (d_rdata),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .pmem_rdata   (pmem_rdata)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic     ir, iw, dr, dw, pr;
    lc3b_word ia, da;
    logic     er, ew, eir, edr;
    lc3b_word ea;
  } vec_t;

  function automatic vec_t mk(input logic ir, input lc3b_word ia,
                              input logic dw, input lc3b_word da, input logic pr,
                              input logic er, input logic ew, input lc3b_word ea,
                              input logic eir, input logic edr);
    vec_t v;
    v.ir = ir; v.iw = 1'b0; v.ia = ia; v.dr = 1'b0; v.dw = dw; v.da = da; v.pr = pr;
    v.er = er; v.ew = ew; v.ea = ea; v.eir = eir; v.edr = edr;
    return v;
  endfunction

  // Waits for a grant, completes it after one cycle, reports who got the resp
  // (0 = I, 1 = D, 2 = no grant, 3 = bad resp) and checks the idle turnaround.
  task automatic serve(output int who);
    bit seen = 0;
    who = 2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin seen = 1; break; end
    end
    if (!seen) begin
      chk("grant_timeout", 128'd0, 128'd1);
      return;
    end
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    if (i_resp && !d_resp)      who = 0;
    else if (d_resp && !i_resp) who = 1;
    else                        who = 3;
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("turnaround_idle", {126'd0, pmem_read, pmem_write}, 128'd0);
  endtask

  vec_t vecs[$];
  int   who;
  int   order[6];

  initial begin
    // Single-requester flows; inputs driven after negedge, checked 1ns later
    vecs.push_back(mk(1, 16'h0040, 0, 16'h0000, 0,  0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 16'h0040, 0, 16'h0000, 0,  1, 0, 16'h0040, 0, 0));
    vecs.push_back(mk(1, 16'h0050, 0, 16'h0000, 1,  1, 0, 16'h0040, 1, 0));
    vecs.push_back(mk(0, 16'h0050, 0, 16'h0000, 0,  0, 0, 16'h0040, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 1,  0, 0, 16'h0040, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0,  0, 0, 16'h0040, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 16'h1230, 0,  0, 0, 16'h0040, 0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 16'h0000, 1, 16'h1230, 0,  0, 1, 16'h1230, 0, 0));
    vecs.push_back(mk(0, 16'h0000, 1, 16'h1230, 1,  0, 1, 16'h1230, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0,  0, 0, 16'h1230, 0, 0));

    rst_n = 1'b0;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = '0; d_address = '0;
    i_wdata = LINE_I; d_wdata = LINE_12; pmem_rdata = LINE_A5;
    repeat (2) @(negedge clk);
    chk("rst_pmem_read",  {127'd0, pmem_read},  128'd0);
    chk("rst_pmem_write", {127'd0, pmem_write}, 128'd0);
    chk("rst_pmem_addr",  {112'd0, pmem_address}, 128'd0);
    chk("rst_pmem_wdata", pmem_wdata, 128'd0);
    chk("rst_resps",      {126'd0, i_resp, d_resp}, 128'd0);
    rst_n = 1'b1;

    foreach (vecs[n]) begin
      @(negedge clk);
      i_read = vecs[n].ir; i_write = vecs[n].iw; i_address = vecs[n].ia;
      d_read = vecs[n].dr; d_write = vecs[n].dw; d_address = vecs[n].da;
      pmem_resp = vecs[n].pr;
      #1;
      chk($sformatf("v%0d_read", n),  {127'd0, pmem_read},  {127'd0, vecs[n].er});
      chk($sformatf("v%0d_write", n), {127'd0, pmem_write}, {127'd0, vecs[n].ew});
      chk($sformatf("v%0d_addr", n),  {112'd0, pmem_address}, {112'd0, vecs[n].ea});
      chk($sformatf("v%0d_i_resp", n), {127'd0, i_resp}, {127'd0, vecs[n].eir});
      chk($sformatf("v%0d_d_resp", n), {127'd0, d_resp}, {127'd0, vecs[n].edr});
      if (vecs[n].ew) chk($sformatf("v%0d_wdata", n), pmem_wdata, LINE_12);
      if (vecs[n].eir) chk("i_rdata", i_rdata, LINE_A5);
      if (vecs[n].edr) chk("d_rdata", d_rdata, LINE_A5);
    end
    pmem_resp = 0;

    // Tie: both reads raised together, each side drops after its resp
    @(negedge clk);
    i_read = 1; i_address = 16'h0100; d_read = 1; d_address = 16'h0200;
    for (int t = 0; t < 2; t++) begin
      serve(who);
      order[t] = who;
      if (who == 0) i_read = 0;
      if (who == 1) d_read = 0;
    end
`ifdef ARB_RR_EN
    chk("tie_first",  128'(order[0]), 128'd0);
    chk("tie_second", 128'(order[1]), 128'd1);
`else
    chk("tie_first",  128'(order[0]), 128'd1);
    chk("tie_second", 128'(order[1]), 128'd0);
`endif

    // Both continuously pending for six transactions
    @(negedge clk);
    i_read = 1; d_read = 1;
    for (int t = 0; t < 6; t++) begin
      serve(who);
      order[t] = who;
    end
    for (int t = 0; t < 6; t++) begin
`ifdef ARB_RR_EN
      chk($sformatf("cont_%0d", t), 128'(order[t]), 128'(t % 2));
`else
      chk($sformatf("cont_%0d", t), 128'(order[t]), 128'd1);
`endif
    end
    i_read = 0; d_read = 0;
    repeat (2) @(negedge clk);

    // Reset asserted mid GRANT_D aborts with no resp
    d_read = 1; d_address = 16'h0300;
    @(negedge clk);
    @(negedge clk);
    chk("grant_d_read", {127'd0, pmem_read}, 128'd1);
    rst_n = 0;
    pmem_resp = 1;
    #1;
    chk("abort_read",   {127'd0, pmem_read}, 128'd0);
    chk("abort_d_resp", {127'd0, d_resp}, 128'd0);
    @(negedge clk);
    d_read = 0; pmem_resp = 0;
    rst_n = 1;
    @(negedge clk);
    pmem_resp = 1;
    #1;
    chk("post_abort_d_resp", {127'd0, d_resp}, 128'd0);
    chk("post_abort_read",   {127'd0, pmem_read, pmem_write}, 128'd0);
    @(negedge clk);
    pmem_resp = 0;
    #1;
    chk("post_abort_idle", {126'd0, pmem_read, pmem_write}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
